// File: rtl/lsu_ctrl_if.sv
// Pipeline-side and memory-side signals of the load/store controller.
// Handshake: a request is accepted on a rising edge where req_valid=1 and
// stall=0. While stall=1 the pipeline must hold req_* steady; the request is
// then accepted on the first edge with stall=0. resp_valid and misalign are
// single-cycle pulses with no back-pressure.
interface lsu_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic [31:0] badaddr;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_result;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_result,
    output stall, resp_valid, resp_rdata, misalign, badaddr,
           mem_addr, mem_read_en, mem_write_en, mem_write_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_result,
    input  stall, resp_valid, resp_rdata, misalign, badaddr,
           mem_addr, mem_read_en, mem_write_en, mem_write_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/halfword/word accesses to a word-wide memory.
// Sub-word stores become a read-modify-write (IDLE read, MERGE write).
module lsu_ctrl (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus,
  output logic      dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_t      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] sdata_q, sdata_d;
  logic        sbyte_q, sbyte_d;

  logic [31:0] word_addr;
  logic [1:0]  lane;
  logic        aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign word_addr = {bus.req_addr[31:2], 2'b00};
  assign lane      = bus.req_addr[1:0];
  assign dbg_state = (state_q == S_MERGE);

  // Alignment check and lane extraction/extension of the memory word
  always_comb begin
    aligned  = 1'b1;
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    load_ext = 32'h0;
    case (bus.req_op)
      OP_LW, OP_SW:         aligned = (lane == 2'b00);
      OP_LH, OP_LHU, OP_SH: aligned = (lane[0] == 1'b0);
      default:              aligned = 1'b1;
    endcase
    case (lane)
      2'd0:    byte_sel = bus.mem_result[7:0];
      2'd1:    byte_sel = bus.mem_result[15:8];
      2'd2:    byte_sel = bus.mem_result[23:16];
      default: byte_sel = bus.mem_result[31:24];
    endcase
    half_sel = lane[1] ? bus.mem_result[31:16] : bus.mem_result[15:0];
    case (bus.req_op)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h0, byte_sel};
      default: load_ext = bus.mem_result;
    endcase
  end

  // Registered word with only the target lane replaced by the store data
  always_comb begin
    merged = word_q;
    if (sbyte_q) begin
      case (lane_q)
        2'd0:    merged[7:0]   = sdata_q[7:0];
        2'd1:    merged[15:8]  = sdata_q[7:0];
        2'd2:    merged[23:16] = sdata_q[7:0];
        default: merged[31:24] = sdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = sdata_q;
    end else begin
      merged[15:0] = sdata_q;
    end
  end

  // Next-state and memory-side outputs; everything forced low while in reset
  always_comb begin
    state_d            = state_q;
    resp_valid_d       = 1'b0;
    resp_rdata_d       = resp_rdata_q;
    misalign_d         = 1'b0;
    badaddr_d          = badaddr_q;
    maddr_d            = maddr_q;
    word_d             = word_q;
    lane_d             = lane_q;
    sdata_d            = sdata_q;
    sbyte_d            = sbyte_q;
    bus.stall          = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_write_data = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (!aligned) begin
            misalign_d = 1'b1;
            badaddr_d  = bus.req_addr;
          end else begin
            bus.mem_addr = word_addr;
            case (bus.req_op)
              OP_SW: begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_data = bus.req_wdata;
              end
              OP_SH, OP_SB: begin
                bus.mem_read_en = 1'b1;
                maddr_d         = word_addr;
                word_d          = bus.mem_result;
                lane_d          = lane;
                sdata_d         = bus.req_wdata[15:0];
                sbyte_d         = (bus.req_op == OP_SB);
                state_d         = S_MERGE;
              end
              default: begin
                bus.mem_read_en = 1'b1;
                resp_valid_d    = 1'b1;
                resp_rdata_d    = load_ext;
              end
            endcase
          end
        end
      end
      default: begin
        bus.stall          = 1'b1;
        bus.mem_write_en   = 1'b1;
        bus.mem_addr       = maddr_q;
        bus.mem_write_data = merged;
        state_d            = S_IDLE;
      end
    endcase
    if (!rst) begin
      bus.stall          = 1'b0;
      bus.mem_read_en    = 1'b0;
      bus.mem_write_en   = 1'b0;
      bus.mem_addr       = 32'h0;
      bus.mem_write_data = 32'h0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      misalign_q   <= 1'b0;
      badaddr_q    <= 32'h0;
      maddr_q      <= 32'h0;
      word_q       <= 32'h0;
      lane_q       <= 2'b00;
      sdata_q      <= 16'h0;
      sbyte_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
      badaddr_q    <= badaddr_d;
      maddr_q      <= maddr_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      sdata_q      <= sdata_d;
      sbyte_q      <= sbyte_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.misalign   = misalign_q;
  assign bus.badaddr    = badaddr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word-wide memory model.
module tb_lsu_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // memory model: combinational read, write on rising edge
  logic [31:0] mem [16];
  logic        pre_en;
  logic [31:0] pre_val;
  assign bus.mem_result = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_en) mem[4] <= pre_val;
    else if (bus.mem_write_en) mem[bus.mem_addr[5:2]] <= bus.mem_write_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_val = val;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    pre_en        = 1'b0;
    pre_val       = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    // reset state
    #12;
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_misalign", {31'h0, bus.misalign}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_badaddr", bus.badaddr, 32'h0);
    chk("rst_mem_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_write_en}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'h0);
    chk("rst_state", {31'h0, dbg_state}, 32'h0);

    load_word(32'h8899AABB);
    @(negedge clk);
    rst = 1'b1;

    // byte loads
    issue(OP_LB, 32'h13, 32'h0);
    chk("lb_re", {31'h0, bus.mem_read_en}, 32'h1);
    chk("lb_addr", bus.mem_addr, 32'h10);
    chk("lb_we", {31'h0, bus.mem_write_en}, 32'h0);
    tick();
    chk("lb_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("lb_data", bus.resp_rdata, 32'hFFFFFF88);
    issue(OP_LBU, 32'h13, 32'h0);
    tick();
    chk("lbu_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("lbu_data", bus.resp_rdata, 32'h00000088);
    idle();
    chk("idle_re", {31'h0, bus.mem_read_en}, 32'h0);
    tick();
    chk("idle_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("idle_hold", bus.resp_rdata, 32'h00000088);

    // back-to-back halfword/word loads
    issue(OP_LH, 32'h12, 32'h0);
    tick();
    chk("lh_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("lh_data", bus.resp_rdata, 32'hFFFF8899);
    issue(OP_LHU, 32'h10, 32'h0);
    tick();
    chk("lhu_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("lhu_data", bus.resp_rdata, 32'h0000AABB);
    issue(OP_LW, 32'h10, 32'h0);
    tick();
    chk("lw_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("lw_data", bus.resp_rdata, 32'h8899AABB);
    idle();
    tick();

    // SB read-modify-write, then a held load of the same word
    issue(OP_SB, 32'h11, 32'h12345677);
    chk("sb1_re", {31'h0, bus.mem_read_en}, 32'h1);
    chk("sb1_we", {31'h0, bus.mem_write_en}, 32'h0);
    chk("sb1_stall", {31'h0, bus.stall}, 32'h0);
    tick();
    chk("sb2_stall", {31'h0, bus.stall}, 32'h1);
    chk("sb2_we", {31'h0, bus.mem_write_en}, 32'h1);
    chk("sb2_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("sb2_wdata", bus.mem_write_data, 32'h889977BB);
    chk("sb2_addr", bus.mem_addr, 32'h10);
    chk("sb2_state", {31'h0, dbg_state}, 32'h1);
    issue(OP_LW, 32'h10, 32'h0);
    chk("sb2_held_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("sb2_held_wdata", bus.mem_write_data, 32'h889977BB);
    tick();
    chk("sb_after_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("sb_after_stall", {31'h0, bus.stall}, 32'h0);
    chk("sb_after_re", {31'h0, bus.mem_read_en}, 32'h1);
    tick();
    chk("sb_lw_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("sb_lw_data", bus.resp_rdata, 32'h889977BB);
    idle();
    tick();

    // misaligned accesses
    issue(OP_LW, 32'h16, 32'h0);
    chk("mis_lw_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("mis_lw_we", {31'h0, bus.mem_write_en}, 32'h0);
    tick();
    chk("mis_lw_pulse", {31'h0, bus.misalign}, 32'h1);
    chk("mis_lw_bad", bus.badaddr, 32'h16);
    chk("mis_lw_valid", {31'h0, bus.resp_valid}, 32'h0);
    issue(OP_SH, 32'h13, 32'h0);
    chk("mis_sh_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("mis_sh_we", {31'h0, bus.mem_write_en}, 32'h0);
    tick();
    chk("mis_sh_pulse", {31'h0, bus.misalign}, 32'h1);
    chk("mis_sh_bad", bus.badaddr, 32'h13);
    chk("mis_sh_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("mis_sh_state", {31'h0, dbg_state}, 32'h0);
    idle();
    tick();
    chk("mis_end_pulse", {31'h0, bus.misalign}, 32'h0);
    chk("mis_end_bad", bus.badaddr, 32'h13);

    // reset during MERGE abandons the write
    load_word(32'h8899AABB);
    issue(OP_SH, 32'h10, 32'h0000CAFE);
    tick();
    chk("shr_we", {31'h0, bus.mem_write_en}, 32'h1);
    chk("shr_wdata", bus.mem_write_data, 32'h8899CAFE);
    rst = 1'b0;
    #1;
    chk("shr_rst_we", {31'h0, bus.mem_write_en}, 32'h0);
    chk("shr_rst_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("shr_rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("shr_rst_addr", bus.mem_addr, 32'h0);
    chk("shr_rst_wdata", bus.mem_write_data, 32'h0);
    chk("shr_rst_rdata", bus.resp_rdata, 32'h0);
    chk("shr_rst_bad", bus.badaddr, 32'h0);
    chk("shr_rst_state", {31'h0, dbg_state}, 32'h0);
    idle();
    tick();
    @(negedge clk);
    rst = 1'b1;
    issue(OP_LW, 32'h10, 32'h0);
    tick();
    chk("shr_lw_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("shr_lw_data", bus.resp_rdata, 32'h8899AABB);

    // SW then LB on the next cycle
    issue(OP_SW, 32'h10, 32'hDEADBEEF);
    chk("sw_we", {31'h0, bus.mem_write_en}, 32'h1);
    chk("sw_re", {31'h0, bus.mem_read_en}, 32'h0);
    chk("sw_wdata", bus.mem_write_data, 32'hDEADBEEF);
    chk("sw_stall", {31'h0, bus.stall}, 32'h0);
    tick();
    issue(OP_LB, 32'h10, 32'h0);
    chk("sw_lb_stall", {31'h0, bus.stall}, 32'h0);
    chk("sw_lb_re", {31'h0, bus.mem_read_en}, 32'h1);
    tick();
    chk("sw_lb_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("sw_lb_data", bus.resp_rdata, 32'hFFFFFFEF);
    idle();
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the MEM pipeline stage and the word-wide data memory. It decodes byte, halfword and word accesses, checks alignment, and drives the memory's word address, read enable, write enable and write data. It sign- or zero-extends load results and returns them registered. The memory only writes whole words, so `SB`/`SH` become a two-cycle read-modify-write; the block stalls the pipeline during the second cycle.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `req_valid`  in  1  a memory op is presented this cycle.
- `req_op`  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (rt); low byte or halfword used for SB/SH.
- `stall`  out  1  pipeline must hold; no new request is accepted.
- `resp_valid`  out  1  load data valid (one-cycle pulse).
- `resp_rdata`  out  32  extended load result.
- `misalign`  out  1  alignment fault pulse.
- `badaddr`  out  32  faulting address, held until the next fault.
- `mem_addr`  out  32  to memory; bits [1:0] always 00.
- `mem_read_en`  out  1  memory read enable.
- `mem_write_en`  out  1  memory write enable.
- `mem_write_data`  out  32  full word to write.
- `mem_result`  in  32  memory read data, combinational in the same cycle.

## Operation
- Byte lanes are little-endian: lane `addr[1:0]`, lane 0 = bits [7:0]. Halfword lane = `addr[1]`.
- Alignment:
  - LW/SW require `addr[1:0]==00`.
  - LH/LHU/SH require `addr[0]==0`.
  - Byte ops are always aligned.
- FSM states: IDLE and MERGE.
- IDLE with `req_valid=1`, request accepted:
  - Misaligned: no memory enable asserted; `misalign` pulses next cycle; `badaddr` <= `req_addr`; no `resp_valid`.
  - Loads: `mem_read_en=1` with `mem_addr={req_addr[31:2],2'b00}`. The selected lane of `mem_result` is captured and extended (LH/LB sign-extend, LHU/LBU zero-extend, LW unchanged). `resp_valid=1` next cycle.
  - SW: `mem_write_en=1`, `mem_write_data=req_wdata`. Stays in IDLE.
  - SH/SB: `mem_read_en=1`. Register the word address, `mem_result`, the lane and the store data. Go to MERGE.
- MERGE:
  - `stall=1`, `mem_write_en=1`, `mem_read_en=0`.
  - `mem_addr` = registered address.
  - `mem_write_data` = registered word with only the target lane replaced.
  - Go to IDLE unconditionally. `req_*` inputs are ignored.
- `stall` is 0 in IDLE.
- Memory enables are combinational from state and `req_*`. All are 0 in reset, and 0 in IDLE when `req_valid=0`.

## Timing
- Reset values:
  - State IDLE.
  - `resp_valid`, `misalign` = 0.
  - `resp_rdata`, `badaddr` = 0.
  - `stall`, `mem_read_en`, `mem_write_en` = 0.
  - `mem_addr`, `mem_write_data` = 0.
- Load latency: request at edge N, `resp_valid` high between edge N+1 and N+2. Back-to-back loads give one response per cycle.
- SW occupies 1 cycle. SH/SB occupy 2 cycles, with `stall` high exactly in the second.
- A load following SH/SB to the same word is accepted only after MERGE and returns the merged word.
- `resp_valid` and `misalign` are never high in the same cycle.
- `resp_rdata` holds its last value when `resp_valid=0`.
- Reset asserted during MERGE:
  - FSM returns to IDLE immediately and `mem_write_en` drops at once, so the partial write is abandoned.
  - The memory word keeps its pre-store value.
- `req_valid` with an undefined `req_op` cannot occur; all 8 codes are defined.

## Test plan
- Word 0x10 preloaded to 0x8899AABB. LB 0x13 -> `resp_rdata` 0xFFFFFF88. LBU 0x13 -> 0x00000088. Each arrives one cycle after the request.
- Same word. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. LW 0x10 -> 0x8899AABB. Sent back-to-back, the three responses come on consecutive cycles.
- SB 0x11 with wdata 0x12345677 -> cycle 1 `mem_read_en=1`. Cycle 2 `stall=1`, `mem_write_en=1`, `mem_write_data`=0x889977BB. A following LW 0x10 returns 0x889977BB.
- LW 0x16, then SH 0x13 -> each gives a `misalign` pulse with `badaddr` 0x16, then 0x13. No memory enable is asserted and there is no `resp_valid`.
- SH 0x10 with wdata 0x0000CAFE, reset asserted in the MERGE cycle -> `mem_write_en` drops immediately and all outputs go to 0. A later LW 0x10 returns 0x8899AABB.
- SW 0x10 with 0xDEADBEEF, then LB 0x10 on the next cycle -> single-cycle write with no stall. Load returns 0xFFFFFFEF.
